// File: rtl/axi_lite_arbiter_n.sv
// axi_lite_arbiter_n: N-to-1 AXI-lite arbiter, independent read and write paths,
// one outstanding transaction per path.
// Ports (all per-master buses are packed, master i occupies slice i):
//   clk, rst                      clock, async active-high reset
//   s_araddr/arvalid/arready      upstream read address
//   s_rdata/rvalid/rready         read data (rdata broadcast, rvalid per master)
//   s_aw*/s_w*                    upstream write address/data/strobe
//   s_bresp/bvalid/bready         write response (bresp broadcast)
//   m_*                           single downstream AXI-lite master port
//   rd_grant/wr_grant             one-hot current owner, 0 when idle
// Build option: define AXI_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority, lowest index wins.
module axi_lite_arbiter_n #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   s_araddr,
    input  logic [NUM_MASTERS-1:0]          s_arvalid,
    output logic [NUM_MASTERS-1:0]          s_arready,
    output logic [DATA_W-1:0]               s_rdata,
    output logic [NUM_MASTERS-1:0]          s_rvalid,
    input  logic [NUM_MASTERS-1:0]          s_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   s_awaddr,
    input  logic [NUM_MASTERS-1:0]          s_awvalid,
    output logic [NUM_MASTERS-1:0]          s_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0]   s_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] s_wstrb,
    input  logic [NUM_MASTERS-1:0]          s_wvalid,
    output logic [NUM_MASTERS-1:0]          s_wready,
    output logic [1:0]                      s_bresp,
    output logic [NUM_MASTERS-1:0]          s_bvalid,
    input  logic [NUM_MASTERS-1:0]          s_bready,
    output logic [ADDR_W-1:0]               m_araddr,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    input  logic [DATA_W-1:0]               m_rdata,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    output logic [ADDR_W-1:0]               m_awaddr,
    output logic                            m_awvalid,
    input  logic                            m_awready,
    output logic [DATA_W-1:0]               m_wdata,
    output logic [DATA_W/8-1:0]             m_wstrb,
    output logic                            m_wvalid,
    input  logic                            m_wready,
    input  logic [1:0]                      m_bresp,
    input  logic                            m_bvalid,
    output logic                            m_bready,
    output logic [NUM_MASTERS-1:0]          rd_grant,
    output logic [NUM_MASTERS-1:0]          wr_grant
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

    r_state_t            r_state_q;
    logic [IDX_W-1:0]    r_g_q;
    logic [ADDR_W-1:0]   r_addr_q;
    w_state_t            w_state_q;
    logic [IDX_W-1:0]    w_g_q;
    logic [ADDR_W-1:0]   w_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                aw_pend_q;
    logic                w_pend_q;

    logic [NUM_MASTERS-1:0] w_req;
    logic [IDX_W-1:0]       r_win_d;
    logic [IDX_W-1:0]       w_win_d;
    logic                   aw_done;
    logic                   w_done;

    // A write is only eligible once both its address and data are offered.
    assign w_req = s_awvalid & s_wvalid;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rd_ptr_q;
    logic [IDX_W-1:0] wr_ptr_q;

    // Search starts just after the last winner.
    function automatic logic [IDX_W-1:0] pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [IDX_W-1:0]       ptr
    );
        logic found;
        int   k;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            k = (int'(ptr) + i) % NUM_MASTERS;
            if (!found && req[IDX_W'(k)]) begin
                pick  = IDX_W'(k);
                found = 1'b1;
            end
        end
    endfunction

    assign r_win_d = pick(s_arvalid, rd_ptr_q);
    assign w_win_d = pick(w_req, wr_ptr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= IDX_W'(NUM_MASTERS - 1);
            wr_ptr_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            if (r_state_q == R_IDLE && |s_arvalid) rd_ptr_q <= r_win_d;
            if (w_state_q == W_IDLE && |w_req)     wr_ptr_q <= w_win_d;
        end
    end
`else
    function automatic logic [IDX_W-1:0] pick(
        input logic [NUM_MASTERS-1:0] req
    );
        pick = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[IDX_W'(i)]) pick = IDX_W'(i);
        end
    endfunction

    assign r_win_d = pick(s_arvalid);
    assign w_win_d = pick(w_req);
`endif

    // Read path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_g_q     <= '0;
            r_addr_q  <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: if (|s_arvalid) begin
                    r_g_q     <= r_win_d;
                    r_addr_q  <= s_araddr[int'(r_win_d)*ADDR_W +: ADDR_W];
                    r_state_q <= R_ADDR;
                end
                R_ADDR: if (m_arready) r_state_q <= R_DATA;
                R_DATA: if (m_rvalid && m_rready) r_state_q <= R_IDLE;
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Write path; aw and w channels retire independently.
    assign aw_done = !aw_pend_q || m_awready;
    assign w_done  = !w_pend_q || m_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_g_q     <= '0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            unique case (w_state_q)
                W_IDLE: if (|w_req) begin
                    w_g_q     <= w_win_d;
                    w_addr_q  <= s_awaddr[int'(w_win_d)*ADDR_W +: ADDR_W];
                    w_data_q  <= s_wdata[int'(w_win_d)*DATA_W +: DATA_W];
                    w_strb_q  <= s_wstrb[int'(w_win_d)*STRB_W +: STRB_W];
                    aw_pend_q <= 1'b1;
                    w_pend_q  <= 1'b1;
                    w_state_q <= W_REQ;
                end
                W_REQ: begin
                    if (m_awready) aw_pend_q <= 1'b0;
                    if (m_wready)  w_pend_q  <= 1'b0;
                    if (aw_done && w_done) w_state_q <= W_RESP;
                end
                W_RESP: if (m_bvalid && m_bready) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        rd_grant  = '0;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        wr_grant  = '0;
        m_rready  = 1'b0;
        m_bready  = 1'b0;
        // Gate with rst so nothing handshakes while reset is held.
        if (!rst && r_state_q == R_IDLE && |s_arvalid) s_arready[r_win_d] = 1'b1;
        if (!rst && w_state_q == W_IDLE && |w_req) begin
            s_awready[w_win_d] = 1'b1;
            s_wready[w_win_d]  = 1'b1;
        end
        if (r_state_q != R_IDLE) rd_grant[r_g_q] = 1'b1;
        if (w_state_q != W_IDLE) wr_grant[w_g_q] = 1'b1;
        if (r_state_q == R_DATA) begin
            m_rready        = s_rready[r_g_q];
            s_rvalid[r_g_q] = m_rvalid;
        end
        if (w_state_q == W_RESP) begin
            m_bready        = s_bready[w_g_q];
            s_bvalid[w_g_q] = m_bvalid;
        end
    end

    assign m_arvalid = (r_state_q == R_ADDR);
    assign m_araddr  = r_addr_q;
    assign s_rdata   = m_rdata;
    assign m_awvalid = (w_state_q == W_REQ) && aw_pend_q;
    assign m_wvalid  = (w_state_q == W_REQ) && w_pend_q;
    assign m_awaddr  = w_addr_q;
    assign m_wdata   = w_data_q;
    assign m_wstrb   = w_strb_q;
    assign s_bresp   = m_bresp;

endmodule

// File: tb/tb_axi_lite_arbiter_n.sv
// tb_axi_lite_arbiter_n: directed bench for axi_lite_arbiter_n,
// a 2-master instance for protocol scenarios and a 4-master one for arbitration order.
module tb_axi_lite_arbiter_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 2-master instance
    logic [63:0] a_s_araddr, a_s_awaddr, a_s_wdata;
    logic [7:0]  a_s_wstrb;
    logic [1:0]  a_s_arvalid, a_s_arready, a_s_rvalid, a_s_rready;
    logic [1:0]  a_s_awvalid, a_s_awready, a_s_wvalid, a_s_wready;
    logic [1:0]  a_s_bresp, a_s_bvalid, a_s_bready, a_rd_grant, a_wr_grant;
    logic [31:0] a_s_rdata, a_m_araddr, a_m_rdata, a_m_awaddr, a_m_wdata;
    logic [3:0]  a_m_wstrb;
    logic        a_m_arvalid, a_m_arready, a_m_rvalid, a_m_rready;
    logic        a_m_awvalid, a_m_awready, a_m_wvalid, a_m_wready;
    logic [1:0]  a_m_bresp;
    logic        a_m_bvalid, a_m_bready;

    // 4-master instance
    logic [127:0] b_s_araddr, b_s_awaddr, b_s_wdata;
    logic [15:0]  b_s_wstrb;
    logic [3:0]   b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready;
    logic [3:0]   b_s_awvalid, b_s_awready, b_s_wvalid, b_s_wready;
    logic [3:0]   b_s_bvalid, b_s_bready, b_rd_grant, b_wr_grant;
    logic [1:0]   b_s_bresp, b_m_bresp;
    logic [31:0]  b_s_rdata, b_m_araddr, b_m_rdata, b_m_awaddr, b_m_wdata;
    logic [3:0]   b_m_wstrb;
    logic         b_m_arvalid, b_m_arready, b_m_rvalid, b_m_rready;
    logic         b_m_awvalid, b_m_awready, b_m_wvalid, b_m_wready;
    logic         b_m_bvalid, b_m_bready;

    axi_lite_arbiter_n #(.NUM_MASTERS(2)) u_a (
        .clk(clk), .rst(rst),
        .s_araddr(a_s_araddr), .s_arvalid(a_s_arvalid), .s_arready(a_s_arready),
        .s_rdata(a_s_rdata), .s_rvalid(a_s_rvalid), .s_rready(a_s_rready),
        .s_awaddr(a_s_awaddr), .s_awvalid(a_s_awvalid), .s_awready(a_s_awready),
        .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wvalid(a_s_wvalid),
        .s_wready(a_s_wready), .s_bresp(a_s_bresp), .s_bvalid(a_s_bvalid),
        .s_bready(a_s_bready), .m_araddr(a_m_araddr), .m_arvalid(a_m_arvalid),
        .m_arready(a_m_arready), .m_rdata(a_m_rdata), .m_rvalid(a_m_rvalid),
        .m_rready(a_m_rready), .m_awaddr(a_m_awaddr), .m_awvalid(a_m_awvalid),
        .m_awready(a_m_awready), .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb),
        .m_wvalid(a_m_wvalid), .m_wready(a_m_wready), .m_bresp(a_m_bresp),
        .m_bvalid(a_m_bvalid), .m_bready(a_m_bready),
        .rd_grant(a_rd_grant), .wr_grant(a_wr_grant)
    );

    axi_lite_arbiter_n #(.NUM_MASTERS(4)) u_b (
        .clk(clk), .rst(rst),
        .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
        .s_rdata(b_s_rdata), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready),
        .s_awaddr(b_s_awaddr), .s_awvalid(b_s_awvalid), .s_awready(b_s_awready),
        .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid),
        .s_wready(b_s_wready), .s_bresp(b_s_bresp), .s_bvalid(b_s_bvalid),
        .s_bready(b_s_bready), .m_araddr(b_m_araddr), .m_arvalid(b_m_arvalid),
        .m_arready(b_m_arready), .m_rdata(b_m_rdata), .m_rvalid(b_m_rvalid),
        .m_rready(b_m_rready), .m_awaddr(b_m_awaddr), .m_awvalid(b_m_awvalid),
        .m_awready(b_m_awready), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
        .m_wvalid(b_m_wvalid), .m_wready(b_m_wready), .m_bresp(b_m_bresp),
        .m_bvalid(b_m_bvalid), .m_bready(b_m_bready),
        .rd_grant(b_rd_grant), .wr_grant(b_wr_grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_s_arvalid = 2'b01;
        a_s_awvalid = 2'b01;
        a_s_wvalid  = 2'b01;
        @(negedge clk);
        checks++; if (a_s_arready !== 2'b00) begin errors++; $display("FAIL rst_arready got=%b exp=00", a_s_arready); end
        checks++; if (a_s_awready !== 2'b00) begin errors++; $display("FAIL rst_awready got=%b exp=00", a_s_awready); end
        checks++; if (a_rd_grant !== 2'b00 || a_wr_grant !== 2'b00) begin errors++; $display("FAIL rst_grants got=%b/%b exp=00/00", a_rd_grant, a_wr_grant); end
        checks++; if ({a_m_arvalid, a_m_awvalid, a_m_wvalid, a_m_rready, a_m_bready} !== 5'b0) begin errors++; $display("FAIL rst_m_ctrl got=%b exp=00000", {a_m_arvalid, a_m_awvalid, a_m_wvalid, a_m_rready, a_m_bready}); end
        checks++; if (a_m_araddr !== 32'h0 || a_m_awaddr !== 32'h0 || a_m_wdata !== 32'h0 || a_m_wstrb !== 4'h0) begin errors++; $display("FAIL rst_regs got=%h/%h/%h/%h exp=0", a_m_araddr, a_m_awaddr, a_m_wdata, a_m_wstrb); end
        a_s_arvalid = 2'b00;
        a_s_awvalid = 2'b00;
        a_s_wvalid  = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_read();
        tick();
        a_s_arvalid = 2'b01;
        a_s_araddr  = 64'h0000_0000_8000_0010;
        @(negedge clk);
        checks++; if (a_s_arready !== 2'b01) begin errors++; $display("FAIL rd_arready got=%b exp=01", a_s_arready); end
        checks++; if (a_rd_grant !== 2'b00) begin errors++; $display("FAIL rd_grant_idle got=%b exp=00", a_rd_grant); end
        tick();
        a_s_arvalid = 2'b00;
        @(negedge clk);
        checks++; if (a_m_arvalid !== 1'b1 || a_m_araddr !== 32'h8000_0010) begin errors++; $display("FAIL rd_m_ar got=%b/%h exp=1/80000010", a_m_arvalid, a_m_araddr); end
        checks++; if (a_rd_grant !== 2'b01) begin errors++; $display("FAIL rd_grant_own got=%b exp=01", a_rd_grant); end
        tick();
        @(negedge clk);
        checks++; if (a_m_arvalid !== 1'b1 || a_m_araddr !== 32'h8000_0010) begin errors++; $display("FAIL rd_ar_hold got=%b/%h exp=1/80000010", a_m_arvalid, a_m_araddr); end
        tick();
        a_m_arready = 1'b1;
        tick();
        a_m_arready = 1'b0;
        a_m_rvalid  = 1'b1;
        a_m_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (a_m_arvalid !== 1'b0) begin errors++; $display("FAIL rd_ar_drop got=%b exp=0", a_m_arvalid); end
        checks++; if (a_s_rvalid !== 2'b01 || a_s_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%b/%h exp=01/deadbeef", a_s_rvalid, a_s_rdata); end
        checks++; if (a_m_rready !== 1'b1) begin errors++; $display("FAIL rd_rready got=%b exp=1", a_m_rready); end
        tick();
        a_m_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (a_rd_grant !== 2'b00 || a_s_rvalid !== 2'b00) begin errors++; $display("FAIL rd_done got=%b/%b exp=00/00", a_rd_grant, a_s_rvalid); end
    endtask

    task automatic test_write_order();
        tick();
        a_s_awvalid = 2'b01;
        a_s_wvalid  = 2'b01;
        a_s_awaddr  = 64'h0000_0000_0000_1000;
        a_s_wdata   = 64'h0000_0000_1234_5678;
        a_s_wstrb   = 8'h0F;
        @(negedge clk);
        checks++; if (a_s_awready !== 2'b01 || a_s_wready !== 2'b01) begin errors++; $display("FAIL wr_s_ready got=%b/%b exp=01/01", a_s_awready, a_s_wready); end
        tick();
        a_s_awvalid = 2'b00;
        a_s_wvalid  = 2'b00;
        a_m_wready  = 1'b1;
        @(negedge clk);
        checks++; if (a_m_awvalid !== 1'b1 || a_m_wvalid !== 1'b1) begin errors++; $display("FAIL wr_m_valid got=%b/%b exp=1/1", a_m_awvalid, a_m_wvalid); end
        checks++; if (a_m_awaddr !== 32'h1000 || a_m_wdata !== 32'h1234_5678 || a_m_wstrb !== 4'hF) begin errors++; $display("FAIL wr_payload got=%h/%h/%h exp=1000/12345678/f", a_m_awaddr, a_m_wdata, a_m_wstrb); end
        checks++; if (a_wr_grant !== 2'b01) begin errors++; $display("FAIL wr_grant_own got=%b exp=01", a_wr_grant); end
        tick();
        a_m_wready = 1'b0;
        @(negedge clk);
        checks++; if (a_m_wvalid !== 1'b0 || a_m_awvalid !== 1'b1) begin errors++; $display("FAIL wr_w_first got=%b/%b exp=w0/aw1", a_m_wvalid, a_m_awvalid); end
        tick();
        tick();
        @(negedge clk);
        checks++; if (a_m_awvalid !== 1'b1 || a_m_bready !== 1'b0) begin errors++; $display("FAIL wr_wait_aw got=%b/%b exp=aw1/bready0", a_m_awvalid, a_m_bready); end
        tick();
        a_m_awready = 1'b1;
        tick();
        a_m_awready = 1'b0;
        a_m_bvalid  = 1'b1;
        a_m_bresp   = 2'b00;
        @(negedge clk);
        checks++; if (a_m_awvalid !== 1'b0 || a_m_bready !== 1'b1) begin errors++; $display("FAIL wr_resp_state got=%b/%b exp=aw0/bready1", a_m_awvalid, a_m_bready); end
        checks++; if (a_s_bvalid !== 2'b01 || a_s_bresp !== 2'b00) begin errors++; $display("FAIL wr_bresp got=%b/%b exp=01/00", a_s_bvalid, a_s_bresp); end
        tick();
        a_m_bvalid = 1'b0;
        @(negedge clk);
        checks++; if (a_wr_grant !== 2'b00) begin errors++; $display("FAIL wr_done got=%b exp=00", a_wr_grant); end
    endtask

    task automatic test_concurrent();
        tick();
        a_s_arvalid = 2'b10;
        a_s_araddr  = 64'h0000_2000_0000_0000;
        a_s_awvalid = 2'b01;
        a_s_wvalid  = 2'b01;
        a_s_awaddr  = 64'h0000_0000_0000_3000;
        a_s_wdata   = 64'h0000_0000_A5A5_A5A5;
        @(negedge clk);
        checks++; if (a_s_arready !== 2'b10 || a_s_awready !== 2'b01) begin errors++; $display("FAIL cc_ready got=%b/%b exp=10/01", a_s_arready, a_s_awready); end
        tick();
        a_s_arvalid = 2'b00;
        a_s_awvalid = 2'b00;
        a_s_wvalid  = 2'b00;
        @(negedge clk);
        checks++; if (a_rd_grant !== 2'b10 || a_wr_grant !== 2'b01) begin errors++; $display("FAIL cc_grants got=%b/%b exp=10/01", a_rd_grant, a_wr_grant); end
        checks++; if (a_m_araddr !== 32'h2000 || a_m_awaddr !== 32'h3000) begin errors++; $display("FAIL cc_addr got=%h/%h exp=2000/3000", a_m_araddr, a_m_awaddr); end
        a_m_arready = 1'b1;
        a_m_awready = 1'b1;
        a_m_wready  = 1'b1;
        tick();
        a_m_arready = 1'b0;
        a_m_awready = 1'b0;
        a_m_wready  = 1'b0;
        a_m_rvalid  = 1'b1;
        a_m_rdata   = 32'h0BAD_F00D;
        a_m_bvalid  = 1'b1;
        a_m_bresp   = 2'b10;
        @(negedge clk);
        checks++; if (a_s_rvalid !== 2'b10 || a_s_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL cc_rvalid got=%b/%h exp=10/0badf00d", a_s_rvalid, a_s_rdata); end
        checks++; if (a_s_bvalid !== 2'b01 || a_s_bresp !== 2'b10) begin errors++; $display("FAIL cc_bvalid got=%b/%b exp=01/10", a_s_bvalid, a_s_bresp); end
        tick();
        a_m_rvalid = 1'b0;
        a_m_bvalid = 1'b0;
        a_m_bresp  = 2'b00;
        @(negedge clk);
        checks++; if (a_rd_grant !== 2'b00 || a_wr_grant !== 2'b00) begin errors++; $display("FAIL cc_done got=%b/%b exp=00/00", a_rd_grant, a_wr_grant); end
    endtask

    task automatic test_reset_mid();
        tick();
        a_s_arvalid = 2'b01;
        a_s_araddr  = 64'h0000_0000_0000_4000;
        tick();
        a_s_arvalid = 2'b00;
        a_m_arready = 1'b1;
        tick();
        a_m_arready = 1'b0;
        @(negedge clk);
        checks++; if (a_rd_grant !== 2'b01 || a_m_rready !== 1'b1) begin errors++; $display("FAIL rm_in_data got=%b/%b exp=01/1", a_rd_grant, a_m_rready); end
        tick();
        rst        = 1'b1;
        a_m_rvalid = 1'b1;
        @(negedge clk);
        checks++; if (a_s_rvalid !== 2'b00 || a_m_rready !== 1'b0 || a_m_arvalid !== 1'b0) begin errors++; $display("FAIL rm_valids got=%b/%b/%b exp=00/0/0", a_s_rvalid, a_m_rready, a_m_arvalid); end
        checks++; if (a_rd_grant !== 2'b00 || a_wr_grant !== 2'b00) begin errors++; $display("FAIL rm_grants got=%b/%b exp=00/00", a_rd_grant, a_wr_grant); end
        tick();
        rst        = 1'b0;
        a_m_rvalid = 1'b0;
        a_s_arvalid = 2'b11;
        @(negedge clk);
        checks++; if (a_s_arready !== 2'b01) begin errors++; $display("FAIL rm_first_win got=%b exp=01", a_s_arready); end
        tick();
        a_s_arvalid = 2'b00;
        a_m_arready = 1'b1;
        tick();
        a_m_arready = 1'b0;
        a_m_rvalid  = 1'b1;
        tick();
        a_m_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (a_rd_grant !== 2'b00) begin errors++; $display("FAIL rm_done got=%b exp=00", a_rd_grant); end
    endtask

    task automatic test_wvalid_gate();
        tick();
        a_s_awvalid = 2'b01;
        a_s_wvalid  = 2'b00;
        a_s_awaddr  = 64'h0000_0000_0000_5000;
        @(negedge clk);
        checks++; if (a_s_awready !== 2'b00 || a_s_wready !== 2'b00) begin errors++; $display("FAIL wg_no_ready got=%b/%b exp=00/00", a_s_awready, a_s_wready); end
        tick();
        @(negedge clk);
        checks++; if (a_wr_grant !== 2'b00 || a_m_awvalid !== 1'b0) begin errors++; $display("FAIL wg_no_grant got=%b/%b exp=00/0", a_wr_grant, a_m_awvalid); end
        tick();
        a_s_wvalid = 2'b01;
        @(negedge clk);
        checks++; if (a_s_awready !== 2'b01 || a_s_wready !== 2'b01) begin errors++; $display("FAIL wg_ready got=%b/%b exp=01/01", a_s_awready, a_s_wready); end
        tick();
        a_s_awvalid = 2'b00;
        a_s_wvalid  = 2'b00;
        a_m_awready = 1'b1;
        a_m_wready  = 1'b1;
        @(negedge clk);
        checks++; if (a_wr_grant !== 2'b01 || a_m_awaddr !== 32'h5000) begin errors++; $display("FAIL wg_grant got=%b/%h exp=01/5000", a_wr_grant, a_m_awaddr); end
        tick();
        a_m_awready = 1'b0;
        a_m_wready  = 1'b0;
        a_m_bvalid  = 1'b1;
        tick();
        a_m_bvalid = 1'b0;
        @(negedge clk);
        checks++; if (a_wr_grant !== 2'b00) begin errors++; $display("FAIL wg_done got=%b exp=00", a_wr_grant); end
    endtask

    task automatic test_arb4();
        logic [3:0] exp_g [5];
        logic [3:0] got_g [5];
        int         got_c [5];
        int         nexp;
        int         n;
`ifdef AXI_ARB_ROUND_ROBIN_EN
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        nexp  = 5;
`else
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        nexp  = 3;
`endif
        n = 0;
        tick();
        b_s_arvalid = 4'hF;
        b_m_arready = 1'b1;
        b_m_rvalid  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (b_s_arready != 4'h0 && n < nexp) begin
                got_g[n] = b_s_arready;
                got_c[n] = c;
                n++;
            end
        end
        tick();
        b_s_arvalid = 4'h0;
        repeat (4) tick();
        b_m_arready = 1'b0;
        b_m_rvalid  = 1'b0;
        checks++; if (n !== nexp) begin errors++; $display("FAIL arb_count got=%0d exp=%0d", n, nexp); end
        for (int k = 0; k < n; k++) begin
            checks++; if (got_g[k] !== exp_g[k]) begin errors++; $display("FAIL arb_order[%0d] got=%b exp=%b", k, got_g[k], exp_g[k]); end
            if (k > 0) begin
                checks++; if (got_c[k] - got_c[k-1] !== 3) begin errors++; $display("FAIL arb_gap[%0d] got=%0d exp=3", k, got_c[k] - got_c[k-1]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_s_araddr = '0; a_s_arvalid = '0; a_s_rready = 2'b11;
        a_s_awaddr = '0; a_s_awvalid = '0; a_s_wdata = '0;
        a_s_wstrb = '0; a_s_wvalid = '0; a_s_bready = 2'b11;
        a_m_arready = 1'b0; a_m_rdata = '0; a_m_rvalid = 1'b0;
        a_m_awready = 1'b0; a_m_wready = 1'b0; a_m_bresp = 2'b00;
        a_m_bvalid = 1'b0;
        b_s_araddr = '0; b_s_arvalid = '0; b_s_rready = 4'hF;
        b_s_awaddr = '0; b_s_awvalid = '0; b_s_wdata = '0;
        b_s_wstrb = '0; b_s_wvalid = '0; b_s_bready = 4'hF;
        b_m_arready = 1'b0; b_m_rdata = '0; b_m_rvalid = 1'b0;
        b_m_awready = 1'b0; b_m_wready = 1'b0; b_m_bresp = 2'b00;
        b_m_bvalid = 1'b0;
        repeat (2) tick();
        test_reset();
        test_read();
        test_write_order();
        test_concurrent();
        test_reset_mid();
        test_wvalid_gate();
        test_arb4();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
